div_ctrl: RTL and testbench
===========================

// Module: div_ctrl
// PURPOSE
//  Sequencer between the CPU pipeline and the 32-iteration unsigned restoring divider. Accepts DIV/DIVU.
//  Signed ops: converts operands to magnitudes, drives the divider, sign-fixes the results.
//  Holds the architectural HI/LO registers (HI=remainder, LO=quotient) and stalls the pipeline while busy.
// PARAMETERS
//  WIDTH  32  operand/result width; must match the divider datapath
// PORTS
//  clock         in   1      system clock, all state on rising edge
//  reset         in   1      synchronous, active-high
//  op_valid      in   1      DIV/DIVU issue request (sampled only in IDLE)
//  op_signed     in   1      1=DIV (two's complement), 0=DIVU
//  op_a          in   WIDTH  dividend (rs)
//  op_b          in   WIDTH  divisor (rt)
//  hi_we, lo_we  in   1      MTHI/MTLO write strobes
//  wdata         in   WIDTH  MTHI/MTLO data
//  hi, lo        out  WIDTH  architectural HI/LO (registered)
//  stall         out  1      pipeline hold
//  done          out  1      one-cycle pulse: HI/LO written this edge
//  div_start     out  1      divider start pulse
//  div_dividend  out  WIDTH  magnitude of dividend, registered
//  div_divisor   out  WIDTH  magnitude of divisor, registered
//  div_busy      in   1      divider busy (rises the cycle after start)
//  div_q, div_r  in   WIDTH  divider quotient/remainder, valid once busy falls
// BEHAVIOUR
//  Reset: state=IDLE; hi=lo=0; stall=done=div_start=0; div_dividend=div_divisor=0.
//  Reset mid-operation aborts: back to IDLE, HI/LO cleared, div_start not reissued. The divider shares reset.
//  FSM states:
//   IDLE:  op_valid -> latch magnitudes into div_dividend/div_divisor.
//          Unsigned: magnitude = raw value. Signed: magnitude = abs(x), with abs(0x80000000)=0x80000000.
//          Also latch neg_q = a[31]^b[31] and neg_r = a[31], both 0 for DIVU. Go to START.
//   START: div_start=1 for exactly this cycle -> ARM.
//   ARM:   one dead cycle; div_busy is not trusted here -> RUN.
//   RUN:   wait while div_busy=1. On div_busy=0, capture div_q/div_r -> FIX.
//   FIX:   lo <= neg_q ? -q : q; hi <= neg_r ? -r : r; done=1 -> IDLE.
//  Latency with 32-cycle divider: op accepted in cycle 0; div_start in cycle 1; busy high in cycles 2..33;
//   done and HI/LO write in cycle 35; new HI/LO visible in cycle 36.
//  stall = (state!=IDLE && state!=FIX) || (state==IDLE && op_valid). Stall is low in the FIX/done cycle.
//  MTHI/MTLO: applied only in IDLE.
//   Simultaneous with op_valid: the write is applied now and overwritten at FIX.
//   Outside IDLE: dropped; the pipeline is stalled, so this is illegal.
//  op_valid outside IDLE is ignored. No queueing.
//  Overflow 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. Results are modulo 2^WIDTH, no trap.
// CONFIGURATION
//  DIV_ZERO_BYPASS_EN defined: if op_b==0 at accept, go IDLE->FIX directly with no div_start.
//   Result: lo=all-ones (DIVU) or, for DIV, op_a[31] ? 1 : all-ones; hi=op_a. done fires in cycle 1.
//  Not defined: divide-by-zero runs through the divider; HI/LO take whatever it returns after sign fix.
// STRUCTURE
//  Package md_pkg: WIDTH default constant; div_state_t enum {IDLE,START,ARM,RUN,FIX}.
//  Sub-module div_sign_fix: combinational abs() and conditional negate, used at IDLE and at FIX.
//  The divider is instantiated by the parent, not inside this block.
// TESTING
//  DIVU 100/7 -> done in cycle 35 after accept; lo=14, hi=2; stall high cycles 0..34; one div_start pulse.
//  DIV -7/2 (0xFFFFFFF9, 2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=-3, hi=1.
//  DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0.
//  Reset asserted in RUN (cycle 10) -> next cycle IDLE, hi=lo=0, stall=0.
//   New DIVU 9/3 afterwards -> lo=3, hi=0.
//  MTHI 0x1234 in IDLE -> hi=0x1234 next cycle. MTLO during RUN -> lo unchanged.
//   op_valid held during RUN -> no second div_start.
//  DIVU 5/0: with DIV_ZERO_BYPASS_EN -> done in cycle 1, lo=0xFFFFFFFF, hi=5, div_start never asserted.
//   Without the macro -> full 35-cycle run.

Source files
------------

// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
//   Shared definitions for the multiply/divide control slice.
//   DIV_WIDTH   : default operand/result width of the divide datapath.
//   div_state_t : sequencer states of div_ctrl.
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    FIX   = 3'd4
  } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// ---------------------------------------------------------------------------
// div_sign_fix
//   Purely combinational sign handling around an unsigned divider.
//   Forward path: magnitudes of the two operands (abs() only for signed ops).
//   Return path : conditional two's complement negation of quotient and
//                 remainder.
// Ports
//   op_signed_i  in   1      1 = operands are two's complement
//   a_i, b_i     in   WIDTH  raw dividend / divisor
//   mag_a_o      out  WIDTH  |a| (raw a when unsigned)
//   mag_b_o      out  WIDTH  |b| (raw b when unsigned)
//   q_i, r_i     in   WIDTH  unsigned quotient / remainder
//   neg_q_i      in   1      negate quotient
//   neg_r_i      in   1      negate remainder
//   fix_q_o      out  WIDTH  signed-corrected quotient
//   fix_r_o      out  WIDTH  signed-corrected remainder
// ---------------------------------------------------------------------------
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic             op_signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] mag_a_o,
  output logic [WIDTH-1:0] mag_b_o,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic             neg_q_i,
  input  logic             neg_r_i,
  output logic [WIDTH-1:0] fix_q_o,
  output logic [WIDTH-1:0] fix_r_o
);

  // Negating the most negative value wraps back to itself, which is exactly
  // the magnitude the unsigned divider needs for it.
  assign mag_a_o = (op_signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
  assign mag_b_o = (op_signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

  assign fix_q_o = neg_q_i ? (~q_i + 1'b1) : q_i;
  assign fix_r_o = neg_r_i ? (~r_i + 1'b1) : r_i;

endmodule

// File: rtl/div_ctrl.sv
// ---------------------------------------------------------------------------
// div_ctrl
//   Sequencer between the CPU pipeline and an external 32-iteration unsigned
//   restoring divider. Handles DIV (signed) and DIVU, owns the architectural
//   HI (remainder) and LO (quotient) registers, and stalls the pipeline while
//   a divide is in flight.
//
//   Optional feature macro: DIV_ZERO_BYPASS_EN
//     When defined, a zero divisor skips the divider: IDLE goes straight to
//     FIX with a quotient of all-ones and a remainder of |op_a|, so after the
//     sign fix lo = all-ones (DIVU) or (op_a<0 ? 1 : all-ones) (DIV) and
//     hi = op_a.
//
// Handshake: op_valid is an issue request sampled only in IDLE; it is
//   accepted on the rising edge of any IDLE cycle where it is high. There is
//   no ready signal: stall is the back-pressure, and it is high in the
//   accepting cycle and every busy cycle up to (not including) FIX. done
//   pulses in the FIX cycle, on whose closing edge HI/LO are written.
//
// Ports
//   clock, reset       in   1      clock; synchronous active-high reset
//   op_valid           in   1      DIV/DIVU issue request
//   op_signed          in   1      1 = DIV, 0 = DIVU
//   op_a, op_b         in   WIDTH  dividend / divisor
//   hi_we, lo_we       in   1      MTHI / MTLO strobes (IDLE only)
//   wdata              in   WIDTH  MTHI / MTLO data
//   hi, lo             out  WIDTH  architectural HI / LO
//   stall              out  1      pipeline hold
//   done               out  1      HI/LO written on this edge
//   div_start          out  1      divider start pulse
//   div_dividend       out  WIDTH  registered dividend magnitude
//   div_divisor        out  WIDTH  registered divisor magnitude
//   div_busy           in   1      divider busy
//   div_q, div_r       in   WIDTH  divider quotient / remainder
//   state_dbg          out  3      current sequencer state (debug)
// ---------------------------------------------------------------------------
module div_ctrl
  import md_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             done,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_busy,
  input  logic [WIDTH-1:0] div_q,
  input  logic [WIDTH-1:0] div_r,
  output logic [2:0]       state_dbg
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] fix_q, fix_r;

  div_sign_fix #(
    .WIDTH (WIDTH)
  ) u_sign_fix (
    .op_signed_i (op_signed),
    .a_i         (op_a),
    .b_i         (op_b),
    .mag_a_o     (mag_a),
    .mag_b_o     (mag_b),
    .q_i         (quo_q),
    .r_i         (rem_q),
    .neg_q_i     (neg_q_q),
    .neg_r_i     (neg_r_q),
    .fix_q_o     (fix_q),
    .fix_r_o     (fix_r)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    div_start  = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Move-to writes land first; an op accepted in the same cycle
        // overwrites them at FIX.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (op_valid) begin
          dividend_d = mag_a;
          divisor_d  = mag_b;
          neg_q_d    = op_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          neg_r_d    = op_signed & op_a[WIDTH-1];
          state_d    = START;
`ifdef DIV_ZERO_BYPASS_EN
          // Preload what the restoring divider would return for /0; the
          // normal sign fix then yields the required HI/LO values.
          if (op_b == '0) begin
            quo_d   = '1;
            rem_d   = mag_a;
            state_d = FIX;
          end
`endif
        end
      end
      START: begin
        div_start = 1'b1;
        state_d   = ARM;
      end
      ARM: begin
        // Divider raises busy only now; its value is not meaningful yet.
        state_d = RUN;
      end
      RUN: begin
        if (!div_busy) begin
          quo_d   = div_q;
          rem_d   = div_r;
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = fix_q;
        hi_d    = fix_r;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign stall = ((state_q != IDLE) && (state_q != FIX)) ||
                 ((state_q == IDLE) && op_valid);

  assign hi           = hi_q;
  assign lo           = lo_q;
  assign div_dividend = dividend_q;
  assign div_divisor  = divisor_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
  import md_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic [W-1:0] hi, lo;
  logic         stall, done, div_start;
  logic [W-1:0] div_dividend, div_divisor;
  logic         div_busy;
  logic [W-1:0] div_q, div_r;
  logic [2:0]   state_dbg;

  always #5 clock = ~clock;

  div_ctrl #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .op_valid     (op_valid),
    .op_signed    (op_signed),
    .op_a         (op_a),
    .op_b         (op_b),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .wdata        (wdata),
    .hi           (hi),
    .lo           (lo),
    .stall        (stall),
    .done         (done),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_busy     (div_busy),
    .div_q        (div_q),
    .div_r        (div_r),
    .state_dbg    (state_dbg)
  );

  // ---------------- divider model: busy for 32 cycles after start ----------
  int unsigned div_cnt;
  always @(posedge clock) begin
    if (reset) begin
      div_cnt <= 0;
      div_q   <= '0;
      div_r   <= '0;
    end else if (div_start) begin
      div_cnt <= 32;
      if (div_divisor == '0) begin
        div_q <= '1;
        div_r <= div_dividend;
      end else begin
        div_q <= div_dividend / div_divisor;
        div_r <= div_dividend % div_divisor;
      end
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 1;
    end
  end
  assign div_busy = (div_cnt != 0);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];   // {hi, lo}

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // HI/LO become visible the cycle after done; compare then.
  logic pend = 1'b0;
  always @(negedge clock) begin
    logic [2*W-1:0] e;
    if (pend) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=%h_%h expected=none", hi, lo);
      end else begin
        e = exp_q.pop_front();
        chk("hi_lo_result", {hi, lo}, e);
      end
    end
    pend = done;
  end

  // ---------------- driver ----------------
  // hold: cycles op_valid stays high; mt_cyc: cycle of an MTLO pulse (0=none)
  task automatic run_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input int exp_lat, input int hold, input int mt_cyc);
    int cyc, starts, stalls;
    bit got;
    logic [W-1:0] lo_before;
    exp_q.push_back({ehi, elo});
    op_valid = 1'b1; op_signed = sgn; op_a = a; op_b = b;
    cyc = 0; starts = 0; stalls = 0; got = 0;
    @(negedge clock);
    chk("stall_accept", {63'b0, stall}, 64'd1);
    lo_before = lo;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock); #1;
      cyc++;
      if (cyc >= hold) op_valid = 1'b0;
      lo_we = (cyc == mt_cyc);
      wdata = 32'hDEAD_BEEF;
      @(negedge clock);
      if (div_start) starts++;
      if (stall) stalls++;
      if (mt_cyc != 0 && cyc == mt_cyc + 1) chk("mtlo_dropped", lo, lo_before);
      if (done) begin
        got = 1;
        break;
      end
    end
    lo_we = 1'b0;
    op_valid = 1'b0;
    chk("done_latency", got ? cyc : -1, exp_lat);
    chk("start_pulses", starts, (exp_lat == 1) ? 0 : 1);
    chk("stall_cycles", stalls, exp_lat - 1);
    @(posedge clock); #1;
  endtask

  task automatic reset_mid_run();
    int starts, dones;
    op_valid = 1'b1; op_signed = 1'b0; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clock); #1;
    op_valid = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("state_run_c10", state_dbg, RUN);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_state", state_dbg, IDLE);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", {63'b0, stall}, 0);
    starts = 0; dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (div_start) starts++;
      if (done) dones++;
    end
    chk("rst_no_restart", starts, 0);
    chk("rst_no_done", dones, 0);
    @(posedge clock); #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_state", state_dbg, IDLE);
    chk("reset_hi_lo", {hi, lo}, 0);
    chk("reset_ctl", {61'b0, stall, done, div_start}, 0);
    chk("reset_div_ops", {div_dividend, div_divisor}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    run_op(1'b0, 32'd100,       32'd7,       32'd14,       32'd2,        35, 1, 0);
    run_op(1'b1, 32'hFFFFFFF9,  32'd2,       32'hFFFFFFFD, 32'hFFFFFFFF, 35, 1, 0);
    run_op(1'b1, 32'd7,         32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,       35, 1, 0);
    run_op(1'b1, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 32'd0,       35, 1, 0);
    run_op(1'b0, 32'hFFFFFFFF,  32'd1,       32'hFFFFFFFF, 32'd0,        35, 1, 0);
    run_op(1'b0, 32'd100,       32'd7,       32'd14,       32'd2,        35, 1, 0);

    // MTHI in IDLE
    hi_we = 1'b1; wdata = 32'h1234;
    @(posedge clock); #1;
    hi_we = 1'b0;
    @(negedge clock);
    chk("mthi_idle", hi, 32'h1234);
    chk("mthi_lo_kept", lo, 32'd14);
    @(posedge clock); #1;

    // op_valid held into RUN and an MTLO during RUN
    run_op(1'b0, 32'd50, 32'd6, 32'd8, 32'd2, 35, 20, 6);

    reset_mid_run();
    run_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 35, 1, 0);

`ifdef DIV_ZERO_BYPASS_EN
    run_op(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, 1, 0);
`else
    run_op(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 35, 1, 0);
`endif

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
